// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit select through the enabled channels of an 8-bit mask,
// holding each for dwell+1 cycles. Optional pause input when SCAN_PAUSE_EN is defined.
module scan_sequencer #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_single_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic [7:0]         mask_i,
`ifdef SCAN_PAUSE_EN
    input  logic               pause_i,
`endif
    output logic               x_o,
    output logic               y_o,
    output logic               z_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               single_q, single_d;
    logic               done_q, done_d;
    logic               hold;

`ifdef SCAN_PAUSE_EN
    assign hold = pause_i;
`else
    assign hold = 1'b0;
`endif

    // Nearest set bit strictly above cur, wrapping 7->0; returns cur if no other bit is set.
    function automatic logic [2:0] next_idx(input logic [2:0] cur, input logic [7:0] m);
        logic [2:0] n;
        logic [2:0] cand;
        n = cur;
        for (int i = 7; i >= 1; i--) begin
            cand = cur + 3'(i);
            if (m[cand]) n = cand;
        end
        return n;
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) n = 3'(i);
        end
        return n;
    endfunction

    logic [2:0] nxt;
    assign nxt = next_idx(idx_q, mask_i);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        single_d = single_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && (mask_i != 8'h00)) begin
                    state_d  = StRun;
                    idx_d    = lowest_idx(mask_i);
                    dwell_d  = dwell_i;
                    single_d = mode_single_i;
                    cnt_d    = '0;
                end
            end
            StRun: begin
                if (stop_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (!hold) begin
                    if (cnt_q == dwell_q) begin
                        cnt_d = '0;
                        if ((mask_i == 8'h00) || (single_q && (nxt <= idx_q))) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = nxt;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            idx_q    <= 3'd0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            single_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            single_q <= single_d;
            done_q   <= done_d;
        end
    end

    assign x_o     = idx_q[2];
    assign y_o     = idx_q[1];
    assign z_o     = idx_q[0];
    assign valid_o = (state_q == StRun);
    assign busy_o  = (state_q == StRun);
    assign done_o  = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: vector table, directed corner sequences and
// randomized stimulus against a behavioural scan model.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, single;
    logic [3:0] dwell;
    logic [7:0] mask;
    logic       x, y, z, valid, busy, done;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .stop_i        (stop),
        .mode_single_i (single),
        .dwell_i       (dwell),
        .mask_i        (mask),
`ifdef SCAN_PAUSE_EN
        .pause_i       (1'b0),
`endif
        .x_o           (x),
        .y_o           (y),
        .z_o           (z),
        .valid_o       (valid),
        .busy_o        (busy),
        .done_o        (done)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: a running flag, the channel shown, and cycles left before moving on.
    bit m_run, m_single, m_done;
    int m_idx, m_left, m_dwell;

    function automatic void model_reset();
        m_run = 0; m_single = 0; m_done = 0; m_idx = 0; m_left = 0; m_dwell = 0;
    endfunction

    function automatic void model_step();
        int j;
        if (!m_run) begin
            m_done = 0;
            if (start && mask != 0) begin
                m_run = 1;
                for (j = 0; j < 8 && !mask[j]; j++) ;
                m_idx = j;
                m_dwell = int'(dwell);
                m_left = m_dwell;
                m_single = single;
            end
        end else begin
            m_done = 0;
            if (stop) begin
                m_run = 0; m_done = 1;
            end else if (m_left > 0) begin
                m_left--;
            end else if (mask == 0) begin
                m_run = 0; m_done = 1;
            end else begin
                int k;
                for (k = 1; k <= 8; k++) if (mask[(m_idx + k) % 8]) break;
                j = (m_idx + k) % 8;
                if (m_single && j <= m_idx) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_idx = j;
                    m_left = m_dwell;
                end
            end
        end
    endfunction

    function automatic logic [5:0] model_out();
        logic [2:0] i3;
        i3 = 3'(m_idx);
        return {i3, m_run, m_run, m_done};
    endfunction

    function automatic logic [5:0] dut_out();
        return {x, y, z, valid, busy, done};
    endfunction

    task automatic check(input string name, input logic [5:0] want);
        logic [5:0] got;
        got = dut_out();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got xyz/valid/busy/done=%b required %b at %0t", name, got, want,
                     $time);
        end
    endtask

    // One clock with the current inputs; model advanced and compared after the edge.
    task automatic step(input string name);
        @(posedge clk);
        #1;
        model_step();
        check(name, model_out());
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; single = 0; dwell = 0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_immediate", 6'b000_000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       start;
        logic       stop;
        logic       single;
        logic [3:0] dwell;
        logic [7:0] mask;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        mask = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 6'b000_000);
        rst_n = 1'b1;

        // Single pass over all eight channels, dwell 0, then empty-mask start and idle stop.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 4'd0, 8'hFF, 6'b000_110};
        for (int i = 1; i < 8; i++) begin
            logic [2:0] i3;
            i3 = 3'(i);
            vecs[i] = '{1'b0, 1'b0, 1'b1, 4'd0, 8'hFF, {i3, 3'b110}};
        end
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd0, 8'hFF, 6'b111_001};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd0, 8'hFF, 6'b111_000};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 6'b111_000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 6'b111_000};
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; single = vecs[i].single;
            dwell = vecs[i].dwell; mask = vecs[i].mask;
            @(posedge clk);
            #1;
            model_step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        idle_inputs();

        // Continuous 2,5,7 with each index held three cycles.
        begin
            int pat[3] = '{2, 5, 7};
            mask = 8'b1010_0100; dwell = 4'd2; single = 0; start = 1;
            for (int s = 0; s < 12; s++) begin
                logic [2:0] e;
                step("cont_model");
                start = 0;
                e = 3'(pat[(s / 3) % 3]);
                check($sformatf("cont_idx_s%0d", s), {e, 3'b110});
            end
            stop = 1;
            step("cont_stop");
            stop = 0;
            step("cont_after_stop");
        end

        // Stop mid-dwell at index 4 in a continuous scan.
        mask = 8'hFF; dwell = 4'd3; single = 0; start = 1;
        for (int s = 0; s <= 16; s++) begin
            step("stop_run");
            start = 0;
        end
        stop = 1;
        step("stop_at4");
        check("stop_at4_holds", 6'b100_001);
        stop = 0;
        step("stop_done_clears");
        check("stop_done_one_cycle", 6'b100_000);

        // Single pass with bit 2 cleared while at index 1; a start pulse mid-scan is ignored.
        mask = 8'h0F; dwell = 4'd1; single = 1; start = 1;
        step("mask_s0");
        start = 0;
        step("mask_s1");
        step("mask_s2");
        check("mask_at1", 6'b001_110);
        mask = 8'h0B; start = 1; dwell = 4'd0; single = 0;
        step("mask_s3");
        start = 0;
        step("mask_s4");
        check("mask_skip_to3", 6'b011_110);
        step("mask_s5");
        step("mask_s6");
        check("mask_single_done", 6'b011_001);
        step("mask_s7");

        // Async reset mid-scan at index 6, then restart from the lowest enabled channel.
        mask = 8'hFF; dwell = 4'd0; single = 0; start = 1;
        for (int s = 0; s <= 6; s++) begin
            step("rst_run");
            start = 0;
        end
        check("rst_at6", 6'b110_110);
        async_reset();
        step("rst_no_done");
        mask = 8'b0011_0000; start = 1;
        step("rst_restart");
        start = 0;
        check("rst_restart_idx4", 6'b100_110);
        step("rst_restart_next");

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            start  = ($urandom % 6) == 0;
            stop   = ($urandom % 40) == 0;
            single = $urandom % 2;
            dwell  = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 3);
            if ($urandom % 12 == 0)
                mask = ($urandom % 4 == 0) ? (8'($urandom) & 8'($urandom) & 8'($urandom))
                                           : 8'($urandom);
            if ($urandom % 700 == 0) begin
                async_reset();
            end else begin
                step("random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Upstream select generator for the 3-to-8 decoder stage. Steps a 3-bit channel index through the enabled channels of an 8-bit mask, holding each index for a programmable dwell time. Drives x/y/z (x = MSB) straight into the decoder select inputs, plus a valid qualifier. Supports single-pass and continuous scan.

Parameters:
DWELL_W, 4, width of dwell input and internal dwell counter; each index held dwell+1 cycles (1..2^DWELL_W).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin scan; sampled only in IDLE
stop  input  1  abort scan; highest priority
mode_single  input  1  1 = one pass then stop, 0 = continuous; sampled with start
dwell  input  DWELL_W  hold count; sampled with start
mask  input  8  per-channel enable, bit i = index i; read live at every advance
x  output  1  index bit 2 (MSB) to decoder
y  output  1  index bit 1 to decoder
z  output  1  index bit 0 (LSB) to decoder
valid  output  1  x/y/z is a live scan index
busy  output  1  high in RUN
done  output  1  one-cycle pulse at end of single pass or on stop

Behaviour:
- All outputs registered. Reset (rst_n low, async): state IDLE, x=y=z=0, valid=0, busy=0, done=0, dwell counter 0.
- States: IDLE, RUN.
- IDLE: valid=0, busy=0; x/y/z hold last value. start=1 and mask!=0 -> RUN; index = lowest set mask bit; latch dwell and mode_single; counter=0. Latency: start sampled at edge k, valid=1 and new index visible after edge k.
- start with mask==0: ignored, stay IDLE, no done.
- RUN: valid=1, busy=1. Counter increments each cycle; when counter == latched dwell, advance: next index = first set mask bit strictly after current, searching upward with wrap 7->0; counter=0.
- Single mode: if the search wraps (next index <= current), or mask now 0 -> IDLE, done=1 for one cycle, valid=0 same cycle.
- Continuous mode: wraps freely; mask now 0 -> IDLE with done pulse.
- Only one enabled channel, continuous: index constant, counter keeps cycling, no glitch on x/y/z.
- Current index deasserted in mask mid-dwell: dwell completes, then skips normally.
- start while RUN: ignored (latched dwell/mode unchanged).
- stop=1 in RUN: next edge -> IDLE, valid=0, done=1 pulse; overrides advance and start same cycle. stop in IDLE: no effect, no done.
- Async reset mid-scan: immediate return to reset values; done not asserted.
- x/y/z change only at advance edges or entry to RUN; never between.

Optional Feature:
SCAN_PAUSE_EN: defined -> adds input port pause (1 bit). In RUN with pause=1 the dwell counter and index freeze, valid stays 1, busy stays 1; stop still honoured; start ignored. Not defined -> no pause port, counter always runs in RUN.

Test Plan:
- Reset then mask=8'hFF, dwell=0, mode_single=1, start 1 cycle -> xyz = 0,1,...,7 each 1 cycle, valid high 8 cycles, done pulse on the cycle valid drops.
- mask=8'b1010_0100, dwell=2, continuous -> xyz sequence 2,5,7,2,5,... each held exactly 3 cycles, done never asserted.
- mask=8'h00, start -> stays IDLE, valid=0, busy=0, done=0.
- Continuous scan mask=8'hFF dwell=3, assert stop at index 4 mid-dwell -> next cycle valid=0, busy=0, done=1 one cycle, xyz holds 4.
- During single-pass scan mask=8'h0F, at index 1 clear mask bit 2 (mask=8'h0B) -> sequence 0,1,3 then done; start pulsed mid-scan has no effect.
- rst_n low for 1 cycle mid-scan at index 6 -> outputs immediately 0, no done; later start resumes from lowest enabled index.
